fp16_norm_pack: RTL
===================

FP16_NORM_PACK -- requirements
Module: fp16_norm_pack

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 in_valid  input  1  upstream offers an unnormalized result.
REQ-004 in_ready  output  1  block accepts an input this cycle.
REQ-005 in_sign  input  1  result sign.
REQ-006 in_exp  input  5  biased exponent associated with mantissa bit 20.
REQ-007 in_mant  input  21  bit 20 is the hidden-one position; bits 19:10 are the fraction; bits 9:0 are guard/sticky.
REQ-008 out_valid  output  1  packed result available.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_data  output  16  packed FP16 value {sign, exp[4:0], frac[9:0]}.
REQ-011 out_ovf  output  1  rounding produced infinity from a finite input.
REQ-012 out_inexact  output  1  guard or sticky bits were nonzero at packing.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; it processes one item at a time.
REQ-014 In IDLE, in_ready=1; on in_valid&in_ready, the block captures sign, mant and exp, replaces exp 0 with 1, and enters SHIFT.
REQ-015 SHIFT shift condition: mant!=0, mant[20]=0 and exp>1; the block shifts mant left 1, decrements exp, and stays in SHIFT; at most one shift per cycle.
REQ-016 SHIFT stop condition (any other case): the block packs via the rounder, loads the output registers, and enters DONE in the same edge.
REQ-017 Latency: out_valid rises k+1 cycles after the accept edge, where k is the number of shifts (0..20).
REQ-018 Pack (mant[20]=1): exp field=exp; frac=mant[19:10].
REQ-019 Pack (mant[20]=0): exp field=0 (subnormal); frac=mant[19:10].
REQ-020 Pack (mant=0): out_data={sign,15'h0}.
REQ-021 Rounding is round-to-nearest-even: guard=mant[9], sticky=|mant[8:0], up=guard&(sticky|frac[0]).
REQ-022 The rounder computes {exp field,frac}+up as a 15-bit add, so frac carry bumps the exponent and a subnormal can round to normal.
REQ-023 out_ovf=1 when the rounded exp field is 31 and the captured exp was below 31; the result is {sign,5'h1F,10'h0}.
REQ-024 out_inexact=guard|sticky.
REQ-025 Captured exp=31 (Inf/NaN): the block does not shift; out_data={sign,5'h1F,mant[19:10]}; out_ovf=0; out_inexact=0.
REQ-026 In DONE, out_valid=1 and out_data/flags hold stable while out_ready=0; in_ready=0 in SHIFT and DONE.
REQ-027 On out_valid&out_ready, the FSM returns to IDLE; a new input is not accepted in that same cycle.

Reset
REQ-028 rst=1 forces IDLE with out_valid=0, out_data=16'h0, out_ovf=0, out_inexact=0, internal mant/exp/sign=0; in_ready=1 the cycle after rst deasserts.
REQ-029 rst in SHIFT or DONE discards the item with no output handshake; rst dominates simultaneous in_valid/out_ready.

Structure
REQ-030 Shared package fp16_pkg holds EXP_W=5, FRAC_W=10, MANT_W=21, EXP_INF=5'h1F, and the FSM state enum.
REQ-031 Rounding and packing (REQ-018..025) SHALL live in a combinational sub-module fp16_round_pack, instantiated once.

Verification
REQ-032 Normal, no shift: sign=0, exp=15, mant=21'h100000 -> out_data=16'h3C00 one cycle after accept, flags 0.
REQ-033 Normalize: exp=15, mant=21'h000400 -> 10 shifts, out_data=16'h1400 at latency 11; sign=1, mant=0 -> 16'h8000 at latency 1.
REQ-034 Subnormal: exp=2, mant=21'h040000 -> one shift, out_data=16'h0200 at latency 2.
REQ-035 Ties/overflow: exp=15, mant=21'h100200 -> 16'h3C00, inexact=1; mant=21'h100600 -> 16'h3C02; exp=30, mant=21'h1FFE00 -> 16'h7C00, ovf=1, inexact=1.
REQ-036 Handshake/reset: hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0; assert rst during SHIFT -> next cycle out_valid=0, in_ready=1, and no result is emitted.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 normalize-and-pack block.
//   EXP_W / FRAC_W / MANT_W : exponent, fraction and unnormalized mantissa widths
//   EXP_INF                 : all-ones exponent (Inf/NaN encoding)
//   state_t                 : normalizer FSM state encoding
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = 21;

  localparam logic [EXP_W-1:0] EXP_INF = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even and FP16 packing of a normalized
// (or subnormal) mantissa/exponent pair.
//   sign    : result sign
//   exp     : biased exponent belonging to mant[20]
//   mant    : bit 20 hidden one, 19:10 fraction, 9 guard, 8:0 sticky
//   data    : packed {sign, exp[4:0], frac[9:0]}
//   ovf     : rounding carried a finite value up to infinity
//   inexact : guard or sticky bits were nonzero
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] mant,
  output logic [15:0]       data,
  output logic              ovf,
  output logic              inexact
);

  logic                      guard;
  logic                      sticky;
  logic                      up;
  logic [FRAC_W-1:0]         frac;
  logic [EXP_W-1:0]          e_field;
  logic [EXP_W+FRAC_W-1:0]   sum;

  always_comb begin
    guard   = mant[9];
    sticky  = |mant[8:0];
    frac    = mant[19:10];
    // Without the hidden one the value is subnormal: exponent field is 0.
    e_field = mant[20] ? exp : '0;
    up      = guard & (sticky | frac[0]);
    // One 15-bit add lets a fraction carry ripple into the exponent field,
    // which also turns a maximal subnormal into the smallest normal.
    sum     = {e_field, frac} + {{(EXP_W+FRAC_W-1){1'b0}}, up};

    data    = '0;
    ovf     = 1'b0;
    inexact = 1'b0;

    if (exp == EXP_INF) begin
      // Inf/NaN passes through untouched, no rounding.
      data = {sign, EXP_INF, frac};
    end else if (mant == '0) begin
      data = {sign, 15'h0};
    end else if (sum[EXP_W+FRAC_W-1:FRAC_W] == EXP_INF) begin
      data    = {sign, EXP_INF, {FRAC_W{1'b0}}};
      ovf     = 1'b1;
      inexact = guard | sticky;
    end else begin
      data    = {sign, sum};
      inexact = guard | sticky;
    end
  end

endmodule

// File: rtl/fp16_norm_pack.sv
// Normalizes an unnormalized FP16 intermediate one left-shift per cycle,
// then rounds and packs it. One item in flight at a time.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : input handshake
//   in_sign/in_exp/in_mant        : unnormalized result (mant bit 20 = hidden one)
//   out_valid/out_ready           : output handshake
//   out_data/out_ovf/out_inexact  : packed FP16 result and flags
//   dbg_state                     : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; out_valid, once raised, stays high with stable data/flags until
// that transfer, and in_ready is high only while no item is held.
module fp16_norm_pack
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              out_ovf,
  output logic              out_inexact,
  output logic [1:0]        dbg_state
);

  state_t            state;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  logic              do_shift;

  logic [15:0]       rp_data;
  logic              rp_ovf;
  logic              rp_inexact;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign dbg_state = state;

  // Keep shifting while the hidden one is missing and the exponent can still
  // drop without leaving the normal range; Inf/NaN is never shifted.
  assign do_shift = (mant_q != '0) && !mant_q[MANT_W-1] &&
                    (exp_q > 5'd1) && (exp_q != EXP_INF);

  fp16_round_pack u_round_pack (
    .sign    (sign_q),
    .exp     (exp_q),
    .mant    (mant_q),
    .data    (rp_data),
    .ovf     (rp_ovf),
    .inexact (rp_inexact)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      out_data    <= 16'h0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            mant_q <= in_mant;
            // Exponent 0 and 1 share the same scale (subnormal encoding).
            exp_q  <= (in_exp == '0) ? 5'd1 : in_exp;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (do_shift) begin
            mant_q <= {mant_q[MANT_W-2:0], 1'b0};
            exp_q  <= exp_q - 5'd1;
          end else begin
            out_data    <= rp_data;
            out_ovf     <= rp_ovf;
            out_inexact <= rp_inexact;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
